jtdsp16_seqctl: RTL

- Parametrised instruction sequencer; the next generation of the DSP16 control path.
- Sits between the program ROM output and the instruction decoder.
- Owns multi-word instruction tracking, the DO/REDO loop cache, PC hold and interrupt inhibit.
- Widths, cache depth and repeat-count width are generic; the previous single-cycle "double" flag becomes a multi-word counter.

---
 rtl/jtdsp16_pkg.sv | 15 +
 rtl/jtdsp16_seq_cache.sv | 25 ++
 rtl/jtdsp16_seqctl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/jtdsp16_pkg.sv
// Shared state type, default widths and K-range helper for the DSP16 sequencer.
package jtdsp16_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} seq_state_t;

    localparam int DEF_DW          = 16;
    localparam int DEF_CACHE_DEPTH = 15;
    localparam int DEF_CNTW        = 7;

    // Largest repeat count a K field of the given width can carry
    function automatic int max_k(input int cntw);
        return (1 << cntw) - 1;
    endfunction

endpackage

// File: rtl/jtdsp16_seq_cache.sv
// Loop body register file: synchronous write qualified by cen, combinational read.
module jtdsp16_seq_cache #(
    parameter int DW    = 16,
    parameter int DEPTH = 15,
    parameter int AW    = 4
)(
    input  logic          clk,
    input  logic          cen,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (cen && wr_en && int'(wr_addr) < DEPTH)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/jtdsp16_seqctl.sv
// DSP16 instruction sequencer: multi-word tracking, DO/REDO loop cache, PC hold, irq inhibit.
// REDO replay is only available when JTDSP16_SEQ_REDO_EN is defined.
module jtdsp16_seqctl
    import jtdsp16_pkg::*;
#(
    parameter int  DW          = DEF_DW,
    parameter int  CACHE_DEPTH = DEF_CACHE_DEPTH,
    parameter int  CNTW        = DEF_CNTW,
    localparam int NW          = $clog2(CACHE_DEPTH + 1)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic [DW-1:0]   ins_in,
    input  logic            do_start,
    input  logic [NW-1:0]   do_ni,
    input  logic [CNTW-1:0] do_k,
    input  logic            redo_start,
    input  logic [1:0]      ext_cnt,
    input  logic            abort,
    output logic [DW-1:0]   ins_out,
    output logic            from_cache,
    output logic            pc_hold,
    output logic            no_int,
    output logic            loop_busy,
    output logic            cache_valid,
    output logic            seq_err,
    output logic [CNTW-1:0] iter_left
);

    seq_state_t      state, state_nxt;
    logic [NW-1:0]   wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt, len, len_nxt;
    logic [CNTW-1:0] iter, iter_nxt;
    logic            valid_nxt, seq_err_nxt, wr_en;
    logic [1:0]      ext_q;
    logic [DW-1:0]   cache_rd;
    logic            do_ok, redo_ok, redo_req;

`ifdef JTDSP16_SEQ_REDO_EN
    assign redo_req = redo_start;
`else
    logic unused_redo;
    assign unused_redo = redo_start;
    assign redo_req    = 1'b0;
`endif

    assign do_ok   = (state == IDLE) && (do_ni != '0) && (int'(do_ni) <= CACHE_DEPTH) && (do_k != '0);
    assign redo_ok = (state == IDLE) && !do_start && cache_valid && (do_k != '0);

    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        len_nxt     = len;
        iter_nxt    = iter;
        valid_nxt   = cache_valid;
        wr_en       = 1'b0;
        seq_err_nxt = (do_start && !do_ok) || (redo_req && (do_start || !redo_ok));
        if (abort) begin
            state_nxt  = IDLE;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            iter_nxt   = '0;
            valid_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_start) begin
                        if (do_ok) begin
                            state_nxt  = FILL;
                            wr_ptr_nxt = '0;
                            len_nxt    = do_ni;
                            iter_nxt   = do_k;
                            valid_nxt  = 1'b0;
                        end
                    end else if (redo_req && redo_ok) begin
                        state_nxt  = RUN;
                        rd_ptr_nxt = '0;
                        iter_nxt   = do_k;
                    end
                end
                FILL: begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + NW'(1);
                    if (wr_ptr == len - NW'(1)) begin
                        valid_nxt  = 1'b1;
                        wr_ptr_nxt = '0;
                        rd_ptr_nxt = '0;
                        iter_nxt   = iter - CNTW'(1);
                        state_nxt  = (iter == CNTW'(1)) ? IDLE : RUN;
                    end
                end
                RUN: begin
                    rd_ptr_nxt = rd_ptr + NW'(1);
                    // Last pass ends at the wrap: iter lands on 0 together with the exit
                    if (rd_ptr == len - NW'(1)) begin
                        rd_ptr_nxt = '0;
                        iter_nxt   = iter - CNTW'(1);
                        if (iter == CNTW'(1))
                            state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (cen)
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            len         <= '0;
            iter        <= '0;
            cache_valid <= 1'b0;
            seq_err     <= 1'b0;
            from_cache  <= 1'b0;
            ext_q       <= 2'd0;
        end else if (cen) begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            len         <= len_nxt;
            iter        <= iter_nxt;
            cache_valid <= valid_nxt;
            seq_err     <= seq_err_nxt;
            from_cache  <= (state_nxt == RUN);
            // Extra-word counter ignores new lengths until the current one drains
            if (ext_q != 2'd0)
                ext_q <= ext_q - 2'd1;
            else
                ext_q <= ext_cnt;
        end
    end

    jtdsp16_seq_cache #(
        .DW    (DW),
        .DEPTH (CACHE_DEPTH),
        .AW    (NW)
    ) u_cache (
        .clk     (clk),
        .cen     (cen),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (ins_in),
        .rd_addr (rd_ptr),
        .rd_data (cache_rd)
    );

    assign ins_out   = from_cache ? cache_rd : ins_in;
    assign pc_hold   = (state == RUN);
    assign loop_busy = (state != IDLE);
    assign iter_left = iter;
    assign no_int    = loop_busy | (ext_q != 2'd0) | do_start | redo_req;

endmodule
